// File: rtl/tiger_debug_tx.sv
`timescale 1ns/1ps
// tiger_debug_tx: processor-to-host debug message queue drained through a serial capture/shift frame port.
// Latency: pushed word is capturable next cycle; readdata valid 1 cycle after read; irq 1 cycle after drain.
// Backpressure: none; DATA writes to a full queue are dropped and flagged in sticky overflow.
module tiger_debug_tx #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       avs_debugTx_address,
   input  logic             avs_debugTx_write,
   input  logic [WIDTH-1:0] avs_debugTx_writedata,
   input  logic             avs_debugTx_read,
   output logic [WIDTH-1:0] avs_debugTx_readdata,
   output logic             avs_debugTx_irq,
   input  logic             host_capture,
   input  logic             host_shift,
   output logic             host_tdo
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wrPtr;
   logic [PW-1:0]    rdPtr;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             irqEn;
   logic [WIDTH:0]   shiftReg;

   logic             dataWr;
   logic             ctrlWr;
   logic             isFull;
   logic             isEmpty;
   logic             doPop;
   logic             doPush;
   logic             dropWr;
   logic             irqSet;
   logic             irqClr;
   logic [WIDTH-1:0] statusWord;
   logic [WIDTH-1:0] rdMux;

   // Decode strobes; a pop in the same cycle frees the slot a full-queue push needs.
   always_comb begin
      dataWr  = avs_debugTx_write && (avs_debugTx_address == 2'd0);
      ctrlWr  = avs_debugTx_write && (avs_debugTx_address == 2'd2);
      isFull  = (count == FULL_CNT);
      isEmpty = (count == '0);
      doPop   = host_capture && !isEmpty;
      doPush  = dataWr && (!isFull || doPop);
      dropWr  = dataWr && isFull && !doPop;
      irqSet  = doPop && !doPush && (count == CW'(1)) && irqEn;
      irqClr  = dataWr || (ctrlWr && !avs_debugTx_writedata[0]);
   end

   // Register read mux: STATUS and CTRL fields, everything else reads zero.
   always_comb begin
      statusWord            = '0;
      statusWord[0]         = isFull;
      statusWord[1]         = isEmpty;
      statusWord[2]         = overflow;
      statusWord[3 +: CW]   = count;
      rdMux                 = '0;
      case (avs_debugTx_address)
         2'd1:    rdMux    = statusWord;
         2'd2:    rdMux[0] = irqEn;
         default: rdMux    = '0;
      endcase
   end

   // Queue storage; contents are don't-care after reset so no reset branch.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= avs_debugTx_writedata;
   end

   // Queue pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PW'(1);
         if (doPop)  rdPtr <= rdPtr + PW'(1);
         case ({doPush, doPop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (dropWr)
            overflow <= 1'b1;
         else if (ctrlWr && avs_debugTx_writedata[1])
            overflow <= 1'b0;
      end
   end

   // Host-facing registers: irq enable, drain interrupt (set beats clear), read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqEn                <= 1'b0;
         avs_debugTx_irq      <= 1'b0;
         avs_debugTx_readdata <= '0;
      end else begin
         if (ctrlWr) irqEn <= avs_debugTx_writedata[0];
         if (irqSet)
            avs_debugTx_irq <= 1'b1;
         else if (irqClr)
            avs_debugTx_irq <= 1'b0;
         if (avs_debugTx_read) avs_debugTx_readdata <= rdMux;
      end
   end

   // Frame shift register: capture loads {head, valid} or zeros, capture beats shift.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shiftReg <= '0;
      end else if (host_capture) begin
         shiftReg <= doPop ? {mem[rdPtr], 1'b1} : '0;
      end else if (host_shift) begin
         shiftReg <= shiftReg >> 1;
      end
   end

   assign host_tdo = shiftReg[0];

endmodule

// File: tb/tb_tiger_debug_tx.sv
`timescale 1ns/1ps
// Bench for tiger_debug_tx: directed scenarios plus randomized traffic against a queue-based model.
module tb_tiger_debug_tx;
   localparam int DEPTH = 4;
   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [1:0]       address = '0;
   logic             write = 1'b0;
   logic [WIDTH-1:0] writedata = '0;
   logic             read = 1'b0;
   logic [WIDTH-1:0] readdata;
   logic             irq;
   logic             capture = 1'b0;
   logic             shift = 1'b0;
   logic             tdo;

   int checks = 0;
   int passes = 0;

   // Reference model state
   logic [WIDTH-1:0] mq[$];
   bit               mOvf = 0;
   bit               mIrqEn = 0;
   bit               mIrq = 0;
   logic [WIDTH:0]   mFrame = '0;
   logic [WIDTH-1:0] mRd = '0;

   tiger_debug_tx #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .avs_debugTx_address   (address),
      .avs_debugTx_write     (write),
      .avs_debugTx_writedata (writedata),
      .avs_debugTx_read      (read),
      .avs_debugTx_readdata  (readdata),
      .avs_debugTx_irq       (irq),
      .host_capture          (capture),
      .host_shift            (shift),
      .host_tdo              (tdo)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] mStatus();
      int n;
      n = mq.size();
      return WIDTH'(n * 8 + (mOvf ? 4 : 0) + (n == 0 ? 2 : 0) + (n == DEPTH ? 1 : 0));
   endfunction

   // One bus/host cycle: drive inputs, advance the model, sample just after the edge.
   task automatic step(input logic [1:0] a, input logic w, input logic [WIDTH-1:0] d,
                       input logic r, input logic c, input logic s);
      bit gotPop;
      bit setIrq;
      gotPop = 0;
      @(negedge clk);
      address = a; write = w; writedata = d; read = r; capture = c; shift = s;
      @(posedge clk);
      if (r) mRd = (a == 2'd1) ? mStatus() : (a == 2'd2) ? WIDTH'(mIrqEn) : '0;
      if (c) begin
         if (mq.size() > 0) begin
            mFrame = {mq.pop_front(), 1'b1};
            gotPop = 1;
         end else begin
            mFrame = '0;
         end
      end else if (s) begin
         mFrame = mFrame >> 1;
      end
      if (w && a == 2'd0) begin
         if (mq.size() < DEPTH) mq.push_back(d);
         else mOvf = 1;
      end
      setIrq = gotPop && (mq.size() == 0) && mIrqEn;
      if (w && a == 2'd2) begin
         mIrqEn = d[0];
         if (d[1]) mOvf = 0;
      end
      if (setIrq) mIrq = 1;
      else if ((w && a == 2'd0) || (w && a == 2'd2 && !d[0])) mIrq = 0;
      #1;
      write = 0; read = 0; capture = 0; shift = 0;
   endtask

   task automatic grab_frame(output logic [WIDTH:0] f);
      f = '0;
      step(2'd0, 0, '0, 0, 1, 0);
      f[0] = tdo;
      for (int i = 1; i <= WIDTH; i++) begin
         step(2'd0, 0, '0, 0, 0, 1);
         f[i] = tdo;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 0;
      mq.delete();
      mOvf = 0; mIrqEn = 0; mIrq = 0; mFrame = '0; mRd = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset_n = 1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (readdata !== '0) $display("FAIL reset_readdata: got %h want 0", readdata); else passes++;
      checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else passes++;
      checks++; if (tdo !== 1'b0) $display("FAIL reset_tdo: got %b want 0", tdo); else passes++;
      release_reset();
      step(2'd1, 0, '0, 1, 0, 0);
      checks++; if (readdata !== 32'h2) $display("FAIL reset_status: got %h want 2", readdata); else passes++;
      step(2'd2, 0, '0, 1, 0, 0);
      checks++; if (readdata !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", readdata); else passes++;
   endtask

   task automatic test_basic();
      logic [WIDTH:0] f;
      step(2'd0, 1, 32'hDEADBEEF, 0, 0, 0);
      grab_frame(f);
      checks++; if (f !== {32'hDEADBEEF, 1'b1}) $display("FAIL basic_frame: got %h want %h", f, {32'hDEADBEEF, 1'b1}); else passes++;
      step(2'd1, 0, '0, 1, 0, 0);
      checks++; if (readdata !== 32'h2) $display("FAIL basic_status_empty: got %h want 2", readdata); else passes++;
   endtask

   task automatic test_overflow();
      logic [WIDTH:0] f;
      for (int k = 1; k <= 5; k++) step(2'd0, 1, WIDTH'(k), 0, 0, 0);
      step(2'd1, 0, '0, 1, 0, 0);
      checks++; if (readdata !== 32'h25) $display("FAIL ovf_status: got %h want 25", readdata); else passes++;
      for (int k = 1; k <= 4; k++) begin
         grab_frame(f);
         checks++; if (f !== {WIDTH'(k), 1'b1}) $display("FAIL ovf_frame%0d: got %h want %h", k, f, {WIDTH'(k), 1'b1}); else passes++;
      end
      step(2'd2, 1, 32'h2, 0, 0, 0);
      step(2'd1, 0, '0, 1, 0, 0);
      checks++; if (readdata !== 32'h2) $display("FAIL ovf_clear_status: got %h want 2", readdata); else passes++;
   endtask

   task automatic test_empty_capture();
      logic [WIDTH:0] f;
      grab_frame(f);
      checks++; if (f !== '0) $display("FAIL empty_frame: got %h want 0", f); else passes++;
      step(2'd1, 0, '0, 1, 0, 0);
      checks++; if (readdata !== 32'h2) $display("FAIL empty_status: got %h want 2", readdata); else passes++;
   endtask

   task automatic test_irq();
      step(2'd2, 1, 32'h1, 0, 0, 0);
      step(2'd2, 0, '0, 1, 0, 0);
      checks++; if (readdata !== 32'h1) $display("FAIL irq_ctrl_read: got %h want 1", readdata); else passes++;
      step(2'd0, 1, 32'h55, 0, 0, 0);
      checks++; if (irq !== 1'b0) $display("FAIL irq_before_pop: got %b want 0", irq); else passes++;
      step(2'd0, 0, '0, 0, 1, 0);
      checks++; if (irq !== 1'b1) $display("FAIL irq_after_drain: got %b want 1", irq); else passes++;
      step(2'd0, 1, 32'h66, 0, 0, 0);
      checks++; if (irq !== 1'b0) $display("FAIL irq_data_clear: got %b want 0", irq); else passes++;
      step(2'd0, 0, '0, 0, 1, 0);
      checks++; if (irq !== 1'b1) $display("FAIL irq_second_drain: got %b want 1", irq); else passes++;
      step(2'd2, 1, 32'h0, 0, 0, 0);
      checks++; if (irq !== 1'b0) $display("FAIL irq_ctrl_clear: got %b want 0", irq); else passes++;
   endtask

   task automatic test_back_to_back();
      logic [WIDTH:0] f;
      logic [WIDTH-1:0] exp [4];
      exp[0] = 32'hA1; exp[1] = 32'hA2; exp[2] = 32'hA3; exp[3] = 32'hB4;
      step(2'd0, 1, 32'hA0, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(2'd0, 1, exp[k], 0, 0, 0);
      // Full queue: push and capture together
      step(2'd0, 1, 32'hB4, 0, 1, 0);
      f = '0;
      f[0] = tdo;
      for (int i = 1; i <= WIDTH; i++) begin
         step(2'd0, 0, '0, 0, 0, 1);
         f[i] = tdo;
      end
      checks++; if (f !== {32'hA0, 1'b1}) $display("FAIL b2b_oldest: got %h want %h", f, {32'hA0, 1'b1}); else passes++;
      step(2'd1, 0, '0, 1, 0, 0);
      checks++; if (readdata !== 32'h21) $display("FAIL b2b_status: got %h want 21", readdata); else passes++;
      for (int k = 0; k < 4; k++) begin
         grab_frame(f);
         checks++; if (f !== {exp[k], 1'b1}) $display("FAIL b2b_drain%0d: got %h want %h", k, f, {exp[k], 1'b1}); else passes++;
      end
      // Empty queue: push and capture together
      step(2'd0, 1, 32'hC5, 0, 1, 0);
      checks++; if (tdo !== 1'b0) $display("FAIL b2b_empty_valid: got %b want 0", tdo); else passes++;
      step(2'd1, 0, '0, 1, 0, 0);
      checks++; if (readdata !== 32'h8) $display("FAIL b2b_empty_status: got %h want 8", readdata); else passes++;
      grab_frame(f);
      checks++; if (f !== {32'hC5, 1'b1}) $display("FAIL b2b_queued: got %h want %h", f, {32'hC5, 1'b1}); else passes++;
   endtask

   task automatic test_random();
      logic [1:0]       a;
      logic [WIDTH-1:0] d;
      logic             w, r, c, s;
      for (int n = 0; n < 600; n++) begin
         a = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) a = 2'd0;
         w = ($urandom_range(0, 9) < 3);
         r = ($urandom_range(0, 9) < 4);
         c = ($urandom_range(0, 9) < 2);
         s = ($urandom_range(0, 9) < 5);
         d = $urandom;
         step(a, w, d, r, c, s);
         checks++; if (readdata !== mRd) $display("FAIL rand_readdata @%0d: got %h want %h", n, readdata, mRd); else passes++;
         checks++; if (irq !== mIrq) $display("FAIL rand_irq @%0d: got %b want %b", n, irq, mIrq); else passes++;
         checks++; if (tdo !== mFrame[0]) $display("FAIL rand_tdo @%0d: got %b want %b", n, tdo, mFrame[0]); else passes++;
      end
   endtask

   task automatic test_midframe_reset();
      step(2'd2, 1, 32'h2, 0, 0, 0);
      step(2'd0, 1, 32'hFFFFFFFF, 0, 0, 0);
      step(2'd0, 0, '0, 0, 1, 0);
      step(2'd0, 1, 32'h12345678, 0, 0, 0);
      step(2'd0, 1, 32'h9ABCDEF0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(2'd0, 0, '0, 0, 0, 1);
      checks++; if (tdo !== 1'b1) $display("FAIL mid_before_reset: got %b want 1", tdo); else passes++;
      apply_reset();
      checks++; if (tdo !== 1'b0) $display("FAIL mid_reset_tdo: got %b want 0", tdo); else passes++;
      checks++; if (irq !== 1'b0) $display("FAIL mid_reset_irq: got %b want 0", irq); else passes++;
      release_reset();
      step(2'd1, 0, '0, 1, 0, 0);
      checks++; if (readdata !== 32'h2) $display("FAIL mid_status: got %h want 2", readdata); else passes++;
      step(2'd0, 0, '0, 0, 1, 0);
      checks++; if (tdo !== 1'b0) $display("FAIL mid_first_capture: got %b want 0", tdo); else passes++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_empty_capture();
      test_irq();
      test_back_to_back();
      test_random();
      test_midframe_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tiger_debug_tx.md
TIGER_DEBUG_TX -- requirements
Module: tiger_debug_tx

Interface
REQ-001 Parameters SHALL be DEPTH, 4, FIFO entries (power of 2, 2..16); WIDTH, 32, message word width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 avs_debugTx_address  input  2  register select: 0 DATA, 1 STATUS, 2 CTRL.
REQ-005 avs_debugTx_write  input  1  Avalon write strobe, single-cycle, no waitrequest.
REQ-006 avs_debugTx_writedata  input  WIDTH  write data.
REQ-007 avs_debugTx_read  input  1  Avalon read strobe, fixed read latency 1.
REQ-008 avs_debugTx_readdata  output  WIDTH  registered read data.
REQ-009 avs_debugTx_irq  output  1  registered level interrupt: "FIFO drained".
REQ-010 host_capture  input  1  one-cycle pulse, already synchronous to clk: load next frame.
REQ-011 host_shift  input  1  one-cycle pulse, already synchronous to clk: advance frame one bit.
REQ-012 host_tdo  output  1  current serial bit to debug host, driven directly from shift register bit 0.

Function
REQ-013 Block SHALL hold a DEPTH x WIDTH FIFO of processor-to-host messages plus a count of 0..DEPTH.
REQ-014 Write to DATA with count<DEPTH SHALL push writedata; count +1 next cycle.
REQ-015 Write to DATA with count==DEPTH SHALL drop the word and set sticky STATUS.overflow.
REQ-016 STATUS read SHALL return bit0 full, bit1 empty, bit2 overflow, bits[7:3] count, upper bits 0.
REQ-017 CTRL read SHALL return bit0 irq_en, others 0; CTRL write SHALL load irq_en from writedata[0] and clear overflow when writedata[1]=1.
REQ-018 DATA read and reads/writes to address 3 SHALL return 0 / have no effect.
REQ-019 readdata SHALL update only on the cycle after a read strobe and hold otherwise.
REQ-020 Shift register SHALL be WIDTH+1 bits; frame = bit0 valid flag, bits[WIDTH:1] data, LSB first.
REQ-021 host_capture with count>0 SHALL load {head word, 1} and pop the FIFO (count -1).
REQ-022 host_capture with count==0 SHALL load all zeros (valid=0); FIFO unchanged.
REQ-023 host_shift SHALL shift right one bit, filling the MSB with 0.
REQ-024 host_capture and host_shift in the same cycle: capture SHALL win, shift ignored.
REQ-025 Push and pop in the same cycle with count==DEPTH SHALL both occur; count unchanged; no overflow.
REQ-026 Push and capture in the same cycle with count==0: capture SHALL see empty (valid=0) and the pushed word SHALL remain queued (count=1).
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 avs_debugTx_irq SHALL be 1 the cycle after count becomes 0 via a pop while irq_en=1.
REQ-029 irq SHALL clear the cycle after any DATA write or a CTRL write with writedata[0]=0; a simultaneous set and clear SHALL resolve to set.

Reset
REQ-030 While reset_n=0: count, pointers, overflow, irq_en, irq, readdata, shift register SHALL be 0; host_tdo=0; FIFO contents need not be cleared.
REQ-031 Reset asserted mid-frame SHALL discard the in-flight frame and all queued words; first capture after reset yields valid=0.

Verification
REQ-032 Write DATA 0xDEADBEEF, capture, 33 shifts -> host_tdo sequence 1 then 0xDEADBEEF LSB-first; STATUS empty=1 afterwards.
REQ-033 Five DATA writes 1..5 with DEPTH=4 -> STATUS full=1, overflow=1, count=4; four captures yield 1,2,3,4.
REQ-034 Capture with FIFO empty -> host_tdo=0 for all 33 bits.
REQ-035 CTRL=1, write one word, capture -> irq=1 one cycle after pop; DATA write -> irq=0 next cycle.
REQ-036 FIFO full, DATA write and capture same cycle -> count stays 4, overflow stays 0, captured word is oldest.
REQ-037 Reset pulse after 10 of 33 shifts -> host_tdo=0, STATUS reads 0x2, irq=0.
